// File: rtl/mul.sv
// mul: sequential signed shift-add multiplier.
//
// Multiplies two signed DATA_MUL-bit operands and returns the signed
// 2*DATA_MUL-bit product DATA_MUL+1 clock edges after the start edge.
// The operands are converted to magnitudes when the operation starts. The
// magnitudes are multiplied with a radix-2 shift-add loop, and the sign is
// applied in a final fix-up cycle. The start/finish handshake matches the
// sequential divider, so the two blocks can be swapped in the sequencer.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   I_EN     in   start request, only sampled while idle
//   I_MCAND  in   signed multiplicand, DATA_MUL bits
//   I_MPLR   in   signed multiplier, DATA_MUL bits
//   O_PRD    out  signed product, 2*DATA_MUL bits, valid while O_FN=1
//   O_FN     out  done level, cleared by the next accepted start
//   O_BUSY   out  high while an operation is in CALC or FIX
module mul #(
  parameter int DATA_MUL = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    I_EN,
  input  logic [DATA_MUL-1:0]     I_MCAND,
  input  logic [DATA_MUL-1:0]     I_MPLR,
  output logic [2*DATA_MUL-1:0]   O_PRD,
  output logic                    O_FN,
  output logic                    O_BUSY
);

  localparam int CW = $clog2(DATA_MUL + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(DATA_MUL);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DATA_MUL-1:0]   ONE_W = {{(DATA_MUL-1){1'b0}}, 1'b1};
  localparam logic [2*DATA_MUL-1:0] ONE_P = {{(2*DATA_MUL-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_MUL-1:0]   mcand_mag;
  logic [DATA_MUL:0]     hi;
  logic [DATA_MUL-1:0]   lo;
  logic [CW-1:0]         cnt;
  logic                  neg;

  logic [DATA_MUL-1:0]   mcand_abs;
  logic [DATA_MUL-1:0]   mplr_abs;
  logic [DATA_MUL-1:0]   addend;
  logic [DATA_MUL:0]     sum;
  logic [2*DATA_MUL-1:0] prod_mag;

  // The most negative operand negates back to itself. Read as unsigned, that
  // value is 2^(W-1), which is the correct magnitude, so no extra bit is needed.
  always_comb begin
    mcand_abs = I_MCAND[DATA_MUL-1] ? (~I_MCAND + ONE_W) : I_MCAND;
    mplr_abs  = I_MPLR[DATA_MUL-1]  ? (~I_MPLR + ONE_W)  : I_MPLR;
  end

  // One shift-add step. hi carries one spare bit so that the carry of the
  // partial sum is kept. That carry then shifts down into hi[W-1].
  always_comb begin
    addend   = lo[0] ? mcand_mag : '0;
    sum      = hi + {1'b0, addend};
    prod_mag = {hi[DATA_MUL-1:0], lo};
  end

  // Next-state logic. The counter starts at DATA_MUL, so CALC runs for
  // exactly DATA_MUL edges before FIX.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (I_EN) state_next = CALC;
      CALC:    if (cnt == CNT_ONE) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath. O_PRD and O_FN hold their values while idle. Only an accepted
  // start clears O_FN, and only FIX updates O_PRD.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mcand_mag <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      O_PRD     <= '0;
      O_FN      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_EN) begin
            mcand_mag <= mcand_abs;
            neg       <= I_MCAND[DATA_MUL-1] ^ I_MPLR[DATA_MUL-1];
            hi        <= '0;
            lo        <= mplr_abs;
            cnt       <= CNT_INIT;
            O_FN      <= 1'b0;
          end
        end
        CALC: begin
          hi  <= {1'b0, sum[DATA_MUL:1]};
          lo  <= {sum[0], lo[DATA_MUL-1:1]};
          cnt <= cnt - CNT_ONE;
        end
        FIX: begin
          // A zero magnitude negates to zero, so a negative zero cannot occur.
          O_PRD <= neg ? (~prod_mag + ONE_P) : prod_mag;
          O_FN  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign O_BUSY = (state == CALC) || (state == FIX);

endmodule
